alu_issue_unit: RTL and testbench
=================================

Name: alu_issue_unit

Overview:
- Initiator-side front end for the existing combinational Alu.
- Accepts operation requests on a valid/ready port, registers the operands, and drives one Alu instance.
- Captures aluout/overflow/compout into an in-order response FIFO and presents them on a valid/ready response port.
- Sits between the decode/control stage and writeback. Also keeps a sticky overflow flag and an operation counter.

Parameters:
WIDTH, 32, operand/result width
DEPTH, 4, response FIFO entries (minimum 2; 4 sustains one op per cycle)
CNT_W, 16, op_count width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  unit can accept request this cycle
req_a  in  WIDTH  operand A
req_b  in  WIDTH  operand B
req_op  in  3  000 and, 001 or, 010 add, 100 nor, 101 xor, 110 sub; 011/111 illegal
req_unsig  in  1  1 = unsigned, 0 = signed (overflow/compare semantics)
rsp_valid  out  1  FIFO head valid
rsp_ready  in  1  consumer takes head
rsp_result  out  WIDTH  head result
rsp_overflow  out  1  head overflow
rsp_compout  out  1  head compare (a<b under req_unsig)
rsp_err  out  1  head was illegal op
ovf_sticky  out  1  set by any enqueued overflow
ovf_clear  in  1  clears ovf_sticky
op_count  out  CNT_W  number of enqueued responses, wraps

Behaviour:
- Reset, async on rst rising, held while high:
  - issue register empty; FIFO empty.
  - rsp_valid=0, rsp_result/overflow/compout/err=0.
  - ovf_sticky=0, op_count=0, req_ready=1 on first cycle after release.
- Reset mid-operation: in-flight issue entry and all FIFO contents are discarded, with no response.
- FSM on the issue register:
  - IDLE: issue empty.
  - ISSUE: holds a, b, op, unsig.
  - Accept (req_valid & req_ready) moves to ISSUE or stays in ISSUE.
  - ISSUE with no accept returns to IDLE at the next edge, since the entry is enqueued.
- req_ready = (fifo_count + issue_valid) < DEPTH.
  - Depends only on registered state; no combinational path from rsp_ready or req_valid.
- Latency: request accepted at edge N; Alu evaluates the registered operands during cycle N..N+1; result enqueued at edge N+1. rsp_valid rises after edge N+1 if the FIFO was empty (2-cycle accept-to-valid).
- Alu semantics, used when checking:
  - add/sub wrap modulo 2^WIDTH.
  - Signed overflow: add when a and b have the same sign and the result sign differs; sub when a and b have opposite signs and the result sign differs from a.
  - Unsigned overflow: add on carry-out; sub on borrow (a<b).
  - Logic ops: overflow=0.
  - compout = a<b (signed or unsigned per unsig) for every op.
- Illegal op (011, 111): enqueue result=0, overflow=0, compout=0, err=1. Order is preserved and op_count increments.
- FIFO:
  - Push and pop in the same cycle are both honoured; count is unchanged.
  - Pop only when rsp_valid & rsp_ready.
  - Push never occurs when full, guaranteed by the req_ready rule; an assertion flags any violation.
  - Response outputs are stable while rsp_valid=1 and rsp_ready=0.
- ovf_sticky: set on the edge that enqueues an overflow=1 entry; cleared by ovf_clear. Simultaneous set and clear: set wins.
- op_count: +1 per enqueue; wraps from 2^CNT_W-1 to 0.

Decomposition:
- Package alu_pkg: op code constants (OP_AND, OP_OR, OP_ADD, OP_NOR, OP_XOR, OP_SUB), op legality function, default WIDTH.
- Sub-module alu_rsp_fifo: synchronous FIFO with count output, width WIDTH+3.
- The Alu itself is instantiated unchanged.

Test Plan:
1. Reset: assert rst with the FIFO half full -> rsp_valid=0, ovf_sticky=0, op_count=0; req_ready=1 after release; no stale responses.
2. Signed add: a=0x7FFFFFFF, b=1, op=010, unsig=0 -> 2 cycles later rsp_result=0x80000000, overflow=1, compout=0; ovf_sticky=1; op_count=1.
3. Unsigned sub: a=3, b=5, op=110, unsig=1 -> result=0xFFFFFFFE, overflow=1, compout=1. Same operands with unsig=0 -> overflow=0, compout=1.
4. Ordering with illegal op: xor(0xF0F0F0F0, 0xFFFF0000), op 011, and(0xFF, 0x0F) -> responses in order: 0x0F0FF0F0/err0, 0/err1, 0x0F/err0.
5. Backpressure: rsp_ready=0, 6 back-to-back requests -> exactly 4 accepted, req_ready=0, outputs stable. Then rsp_ready=1 -> 4 responses in order, after which the remaining requests are accepted.
6. Throughput/sticky: rsp_ready=1, 10 consecutive adds -> one accept per cycle, op_count=10. ovf_clear asserted on the same edge as an overflow enqueue -> ovf_sticky stays 1.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Brief    : Shared op codes, issue FSM encoding and op legality check.
// Revision : 1.0
// ============================================================================
package alu_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_NOR = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } issue_state_t;

  function automatic logic op_is_legal(input logic [2:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_NOR, OP_XOR, OP_SUB: return 1'b1;
      default:                                       return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
// Module   : alu
// Brief    : Combinational ALU: logic ops, add/sub with overflow, a<b compare.
// Revision : 1.0
// ============================================================================
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             unsig,
  output logic [WIDTH-1:0] aluout,
  output logic             overflow,
  output logic             compout
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_diff;
  logic           w_slt;

  // The extra top bit of w_sum is carry-out; of w_diff it is the unsigned borrow.
  assign w_sum  = {1'b0, a} + {1'b0, b};
  assign w_diff = {1'b0, a} - {1'b0, b};
  assign w_slt  = $signed(a) < $signed(b);

  always_comb begin
    aluout   = '0;
    overflow = 1'b0;
    compout  = unsig ? w_diff[WIDTH] : w_slt;
    case (op)
      OP_AND: aluout = a & b;
      OP_OR:  aluout = a | b;
      OP_NOR: aluout = ~(a | b);
      OP_XOR: aluout = a ^ b;
      OP_ADD: begin
        aluout   = w_sum[WIDTH-1:0];
        overflow = unsig ? w_sum[WIDTH]
                         : (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        aluout   = w_diff[WIDTH-1:0];
        overflow = unsig ? w_diff[WIDTH]
                         : (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
      end
      default: begin
        aluout   = '0;
        overflow = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_rsp_fifo.sv
`default_nettype none
// ============================================================================
// Module   : alu_rsp_fifo
// Brief    : Synchronous in-order FIFO with occupancy count; push+pop same cycle.
// Revision : 1.0
// ============================================================================
module alu_rsp_fifo #(
  parameter int WIDTH = 35,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_push,
  input  logic [WIDTH-1:0]             i_data,
  input  logic                         i_pop,
  output logic [WIDTH-1:0]             o_data,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_empty
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] C_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_full;
  logic             w_push;
  logic             w_pop;

  assign w_full  = (r_count == C_FULL);
  assign o_empty = (r_count == '0);
  assign w_push  = i_push & ~w_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  // Storage carries no reset; validity is tracked entirely by r_count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == C_LAST) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == C_LAST) ? '0 : r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  a_no_push_when_full: assert property (@(posedge clk) disable iff (rst) !(i_push && w_full));

endmodule
`default_nettype wire

// File: rtl/alu_issue_unit.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_unit
// Brief    : Valid/ready front end for the ALU with in-order response FIFO,
//            sticky overflow flag and enqueue counter.
// Revision : 1.0
// ============================================================================
module alu_issue_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [2:0]       req_op,
  input  logic             req_unsig,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_overflow,
  output logic             rsp_compout,
  output logic             rsp_err,
  output logic             ovf_sticky,
  input  logic             ovf_clear,
  output logic [CNT_W-1:0] op_count
);

  localparam int FC_W    = $clog2(DEPTH+1);
  localparam int ENTRY_W = WIDTH + 3;
  localparam logic [FC_W:0] C_DEPTH = (FC_W+1)'(DEPTH);

  issue_state_t     r_state;
  issue_state_t     w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [2:0]       r_op;
  logic             r_unsig;

  logic             w_issue_valid;
  logic             w_accept;
  logic             w_pop;
  logic             w_legal;
  logic             w_fifo_empty;
  logic [FC_W-1:0]  w_fifo_count;
  logic [FC_W:0]    w_occupancy;
  logic [WIDTH-1:0] w_aluout;
  logic             w_alu_ovf;
  logic             w_alu_cmp;
  logic             w_push_ovf;
  logic [ENTRY_W-1:0] w_push_data;
  logic [ENTRY_W-1:0] w_head;

  // Issue entry counts against capacity so an accepted op always has a FIFO slot.
  assign w_issue_valid = (r_state == ST_ISSUE);
  assign w_occupancy   = {1'b0, w_fifo_count} + {{FC_W{1'b0}}, w_issue_valid};
  assign req_ready     = (w_occupancy < C_DEPTH);
  assign w_accept      = req_valid & req_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  w_state_next = w_accept ? ST_ISSUE : ST_IDLE;
      ST_ISSUE: w_state_next = w_accept ? ST_ISSUE : ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_unsig <= 1'b0;
    end else if (w_accept) begin
      r_a     <= req_a;
      r_b     <= req_b;
      r_op    <= req_op;
      r_unsig <= req_unsig;
    end
  end

  alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .a        (r_a),
    .b        (r_b),
    .op       (r_op),
    .unsig    (r_unsig),
    .aluout   (w_aluout),
    .overflow (w_alu_ovf),
    .compout  (w_alu_cmp)
  );

  // Illegal ops still occupy a slot in order, flagged by err with all else zero.
  assign w_legal     = op_is_legal(r_op);
  assign w_push_ovf  = w_legal & w_alu_ovf;
  assign w_push_data = w_legal ? {1'b0, w_alu_cmp, w_alu_ovf, w_aluout}
                               : {1'b1, 1'b0, 1'b0, {WIDTH{1'b0}}};

  alu_rsp_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_rsp_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_issue_valid),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_count (w_fifo_count),
    .o_empty (w_fifo_empty)
  );

  assign rsp_valid = ~w_fifo_empty;
  assign w_pop     = rsp_valid & rsp_ready;
  assign {rsp_err, rsp_compout, rsp_overflow, rsp_result} = rsp_valid ? w_head : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_sticky <= 1'b0;
      op_count   <= '0;
    end else begin
      if (w_issue_valid && w_push_ovf) begin
        ovf_sticky <= 1'b1;
      end else if (ovf_clear) begin
        ovf_sticky <= 1'b0;
      end
      if (w_issue_valid) begin
        op_count <= op_count + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_alu_issue_unit
// Brief    : Directed table-driven bench for alu_issue_unit.
// Revision : 1.0
// ============================================================================
module tb_alu_issue_unit;
  import alu_pkg::*;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [2:0]       req_op;
  logic             req_unsig;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_overflow;
  logic             rsp_compout;
  logic             rsp_err;
  logic             ovf_sticky;
  logic             ovf_clear;
  logic [CNT_W-1:0] op_count;

  always #5 clk = ~clk;

  alu_issue_unit #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_op       (req_op),
    .req_unsig    (req_unsig),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_overflow (rsp_overflow),
    .rsp_compout  (rsp_compout),
    .rsp_err      (rsp_err),
    .ovf_sticky   (ovf_sticky),
    .ovf_clear    (ovf_clear),
    .op_count     (op_count)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic        unsig;
    logic [31:0] res;
    logic        ovf;
    logic        cmp;
    logic        err;
  } vec_t;

  vec_t vecs [30];
  int   n_vec  = 0;
  int   n_miss = 0;

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                              input logic u, input logic [31:0] r, input logic o,
                              input logic c, input logic e);
    vec_t v;
    v.a = a; v.b = b; v.op = op; v.unsig = u; v.res = r; v.ovf = o; v.cmp = c; v.err = e;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int i);
    req_a     = vecs[i].a;
    req_b     = vecs[i].b;
    req_op    = vecs[i].op;
    req_unsig = vecs[i].unsig;
    req_valid = 1'b1;
  endtask

  task automatic produce(input int lo, input int hi, output int stalls);
    stalls = 0;
    for (int i = lo; i < hi; i++) begin
      drive(i);
      for (int k = 0; k < 50 && !req_ready; k++) begin
        tick();
        stalls++;
      end
      if (!req_ready) begin
        check("req_ready_timeout", {63'b0, req_ready}, 64'd1);
        break;
      end
      tick();
    end
    req_valid = 1'b0;
  endtask

  task automatic consume(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      for (int k = 0; k < 50 && !rsp_valid; k++) tick();
      check("rsp_valid_wait", {63'b0, rsp_valid}, 64'd1);
      if (!rsp_valid) break;
      check("rsp_result",   {32'b0, rsp_result},   {32'b0, vecs[i].res});
      check("rsp_overflow", {63'b0, rsp_overflow}, {63'b0, vecs[i].ovf});
      check("rsp_compout",  {63'b0, rsp_compout},  {63'b0, vecs[i].cmp});
      check("rsp_err",      {63'b0, rsp_err},      {63'b0, vecs[i].err});
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  initial begin
    int st;
    int acc;
    logic rdy;

    vecs[0]  = mk(32'h7FFFFFFF, 32'h1,        OP_ADD, 1'b0, 32'h80000000, 1'b1, 1'b0, 1'b0);
    vecs[1]  = mk(32'h3,        32'h5,        OP_SUB, 1'b1, 32'hFFFFFFFE, 1'b1, 1'b1, 1'b0);
    vecs[2]  = mk(32'h3,        32'h5,        OP_SUB, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b1, 1'b0);
    vecs[3]  = mk(32'hF0F0F0F0, 32'hFFFF0000, OP_XOR, 1'b0, 32'h0F0FF0F0, 1'b0, 1'b1, 1'b0);
    vecs[4]  = mk(32'h1,        32'h2,        3'b011, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1);
    vecs[5]  = mk(32'hFF,       32'h0F,       OP_AND, 1'b0, 32'h0F,       1'b0, 1'b0, 1'b0);
    vecs[6]  = mk(32'h12340000, 32'h00005678, OP_OR,  1'b1, 32'h12345678, 1'b0, 1'b0, 1'b0);
    vecs[7]  = mk(32'h0,        32'h0,        OP_NOR, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
    vecs[8]  = mk(32'hFFFFFFFF, 32'h2,        OP_ADD, 1'b1, 32'h1,        1'b1, 1'b0, 1'b0);
    vecs[9]  = mk(32'hFFFFFFFF, 32'h2,        OP_ADD, 1'b0, 32'h1,        1'b0, 1'b1, 1'b0);
    vecs[10] = mk(32'h80000000, 32'h1,        OP_SUB, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);
    vecs[11] = mk(32'h80000000, 32'h1,        OP_SUB, 1'b1, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b0);
    vecs[12] = mk(32'h5,        32'h5,        3'b111, 1'b1, 32'h0,        1'b0, 1'b0, 1'b1);
    vecs[13] = mk(32'h80000000, 32'h80000000, OP_ADD, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++)
      vecs[14+i] = mk(32'(i), 32'h10, OP_OR, 1'b1, 32'(16 + i), 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++)
      vecs[20+i] = mk(32'(i * 256), 32'(i), OP_ADD, 1'b1, 32'(i * 257), 1'b0, 1'b0, 1'b0);

    // Reset state
    rst = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_op = '0; req_unsig = 1'b0;
    rsp_ready = 1'b0; ovf_clear = 1'b0;
    #12;
    check("rst_rsp_valid",  {63'b0, rsp_valid},  64'd0);
    check("rst_rsp_result", {32'b0, rsp_result}, 64'd0);
    check("rst_ovf_sticky", {63'b0, ovf_sticky}, 64'd0);
    check("rst_op_count",   {48'b0, op_count},   64'd0);
    tick();
    rst = 1'b0;
    check("post_rst_req_ready", {63'b0, req_ready}, 64'd1);

    // Two-cycle accept-to-valid latency on signed add overflow
    drive(0);
    tick();
    req_valid = 1'b0;
    check("lat_valid_early", {63'b0, rsp_valid}, 64'd0);
    tick();
    check("lat_valid",    {63'b0, rsp_valid},    64'd1);
    check("lat_result",   {32'b0, rsp_result},   {32'b0, vecs[0].res});
    check("lat_overflow", {63'b0, rsp_overflow}, 64'd1);
    check("lat_compout",  {63'b0, rsp_compout},  64'd0);
    check("lat_sticky",   {63'b0, ovf_sticky},   64'd1);
    check("lat_op_count", {48'b0, op_count},     64'd1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("lat_popped", {63'b0, rsp_valid}, 64'd0);

    // Main table, streamed with consumer always ready
    rsp_ready = 1'b1;
    fork
      produce(1, 14, st);
      consume(1, 14);
    join
    check("table_op_count", {48'b0, op_count}, 64'd14);

    // Backpressure: only DEPTH requests fit while the consumer stalls
    rsp_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      drive(14 + ((acc < 6) ? acc : 5));
      rdy = req_ready;
      tick();
      if (rdy) acc++;
      if (c >= 3) begin
        check("bp_valid",       {63'b0, rsp_valid},  64'd1);
        check("bp_head_stable", {32'b0, rsp_result}, {32'b0, vecs[14].res});
      end
    end
    check("bp_accepted",  64'(acc),             64'd4);
    check("bp_req_ready", {63'b0, req_ready},   64'd0);
    rsp_ready = 1'b1;
    fork
      produce(14 + ((acc < 6) ? acc : 6), 20, st);
      consume(14, 20);
    join

    // Throughput: one accept per cycle with a ready consumer
    fork
      produce(20, 30, st);
      consume(20, 30);
    join
    check("thr_stalls",   64'(st),            64'd0);
    check("thr_op_count", {48'b0, op_count},  64'd30);
    rsp_ready = 1'b0;

    // Sticky flag: clear alone, then set beats clear on the same edge
    ovf_clear = 1'b1;
    tick();
    ovf_clear = 1'b0;
    check("sticky_clear", {63'b0, ovf_sticky}, 64'd0);
    drive(0);
    tick();
    req_valid = 1'b0;
    ovf_clear = 1'b1;
    tick();
    check("sticky_set_wins", {63'b0, ovf_sticky}, 64'd1);
    tick();
    check("sticky_cleared_after", {63'b0, ovf_sticky}, 64'd0);
    ovf_clear = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("sticky_seq_drained", {63'b0, rsp_valid}, 64'd0);

    // Asynchronous reset with the FIFO partly full
    produce(1, 3, st);
    tick();
    tick();
    check("pre_rst_valid",  {63'b0, rsp_valid},  64'd1);
    check("pre_rst_sticky", {63'b0, ovf_sticky}, 64'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid",    {63'b0, rsp_valid},  64'd0);
    check("mid_rst_result",   {32'b0, rsp_result}, 64'd0);
    check("mid_rst_sticky",   {63'b0, ovf_sticky}, 64'd0);
    check("mid_rst_op_count", {48'b0, op_count},   64'd0);
    tick();
    tick();
    rst = 1'b0;
    check("rel_req_ready", {63'b0, req_ready}, 64'd1);
    rsp_ready = 1'b1;
    repeat (4) tick();
    check("no_stale_rsp",      {63'b0, rsp_valid}, 64'd0);
    check("no_stale_op_count", {48'b0, op_count},  64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
